product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
Downstream stage of the combinational shift-add multiplier (multiplyShiftAdd).
- Consumes its 2n-bit product Z through a valid/ready handshake.
- Sums LEN consecutive products into one dot-product result and presents it on an output handshake.
- Turns the multiplier into a sequential MAC datapath with explicit run start, completion and overflow reporting.

Parameters:
n, 4, multiplier operand width; product width is 2n.
LEN, 4, products accumulated per run; LEN >= 1.
G, 4, accumulator guard bits; accumulator width W = 2n+G.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  begins a run; honoured only in IDLE.
in_valid  input  1  prod holds a valid product this cycle.
in_ready  output  1  block accepts prod this cycle.
prod  input  2n  product from multiplier Z (unsigned).
acc_out  output  2n+G  accumulator register contents.
out_valid  output  1  acc_out holds a completed run result.
out_ready  input  1  consumer takes the result.
busy  output  1  high in ACCUM or DONE.
overflow  output  1  sticky: carry out of the W-bit accumulator occurred during the current run.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); all state changes on the rising edge of clk.
- Reset values: state = IDLE, acc_out = 0, count = 0, overflow = 0, in_ready = 0, out_valid = 0, busy = 0.
- Reset asserted mid-run aborts the run immediately; partial sum is discarded and no out_valid is produced.
- Outputs are registered/state-decoded: in_ready = (state==ACCUM), out_valid = (state==DONE), busy = (state!=IDLE).

State machine:
- IDLE:
  - start = 1 -> ACCUM next cycle; acc_out <= 0, count <= 0, overflow <= 0 on the same edge.
- ACCUM:
  - Accept when in_valid & in_ready: acc_out <= acc_out + zero-extended prod (mod 2^W); count <= count+1.
  - overflow <= overflow | carry-out of that add.
  - No accept -> all state held. Gaps in in_valid are allowed and are arbitrary in length.
  - When the accepted product is the LEN-th (count == LEN-1 at the edge) -> DONE.
- DONE:
  - acc_out frozen at the final sum; out_valid = 1, held until out_ready = 1.
  - out_valid & out_ready -> IDLE next cycle; acc_out and overflow keep their values in IDLE until the next start.
- start is ignored in ACCUM and DONE; a new run requires returning to IDLE. start in the same cycle as the DONE->IDLE transition is ignored.
- Latency: out_valid rises the cycle after the LEN-th accept. Minimum run = 1 (start) + LEN (accepts) + 1 (handshake) cycles.
- Throughput: one product per cycle in ACCUM.
- prod is ignored whenever in_ready = 0.

Arithmetic:
- Unsigned only; wraps modulo 2^W.
- overflow is informational and does not alter the wrapped sum.
- With G >= ceil(log2(LEN)), overflow can never assert.
- LEN = 1: single accept goes directly to DONE.

Test Plan:
- Basic run, n=4, LEN=4, G=4: start, then products 2, 42, 180, 15 with in_valid every cycle -> out_valid one cycle after the 4th accept; acc_out = 239 (12'h0EF); overflow = 0.
- Input gaps: same four products with 1–3 idle cycles between in_valid pulses -> acc_out = 239; in_ready stays 1 throughout ACCUM; count advances only on accepts.
- Overflow, G=1 (W=9): four products of 225 -> acc_out = 900 mod 512 = 388; overflow = 1 in DONE. Following run 1+1+1+1 -> acc_out = 4, overflow = 0.
- Output backpressure: hold out_ready = 0 for 5 cycles in DONE -> out_valid and acc_out stable; in_ready = 0; extra in_valid ignored; start ignored. out_ready = 1 -> IDLE next cycle.
- Reset mid-run: rst after 2 accepts -> next cycle IDLE, acc_out = 0, busy = 0. Fresh run of 3, 3, 3, 3 -> acc_out = 12.
- LEN=1 corner: start, prod = 225 -> DONE after one accept; acc_out = 225.

Source files
------------

// File: rtl/product_accumulator.sv
// Sums LEN consecutive multiplier products into one W-bit result; out_valid rises the cycle after the LEN-th accept.
// Backpressure: in_ready only in ACCUM; the result is held in DONE until out_ready, with no new products taken.
module product_accumulator #(
  parameter int n   = 4,
  parameter int LEN = 4,
  parameter int G   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*n-1:0]   prod,
  output logic [2*n+G-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow
);

  localparam int W  = 2*n + G;
  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;
  logic          accept;
  logic          last_accept;
  logic [W:0]    sum;

  assign accept      = in_valid & in_ready;
  assign last_accept = accept & (count == LAST);
  // One extra bit on the adder captures the carry out of the W-bit accumulator.
  assign sum         = {1'b0, acc_out} + {{(G+1){1'b0}}, prod};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)       state_nxt = ACCUM;
      ACCUM:   if (last_accept) state_nxt = DONE;
      DONE:    if (out_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // acc_out and overflow keep the last result through IDLE until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out  <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      acc_out  <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      acc_out  <= sum[W-1:0];
      count    <= count + CW'(1);
      overflow <= overflow | sum[W];
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (default, G=1, LEN=1) driven with directed and random runs.
// An integer-sum model predicts every output each cycle; literal sums pin the model on the known scenarios.
module tb_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_s [3];
  logic        iv_s    [3];
  logic        ordy_s  [3];
  logic [7:0]  prod_s  [3];
  logic        ir_a    [3];
  logic        ovl_a   [3];
  logic        busy_a  [3];
  logic        ovf_a   [3];
  logic [11:0] acc_a   [3];
  logic [8:0]  acc1;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  bit     mbusy  [3];
  int     mtaken [3];
  longint msum   [3];

  function automatic int lenv(int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int wv(int i);
    return (i == 1) ? 9 : 12;
  endfunction

  product_accumulator #(.n(4), .LEN(4), .G(4)) u0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .in_valid(iv_s[0]), .in_ready(ir_a[0]),
    .prod(prod_s[0]), .acc_out(acc_a[0]), .out_valid(ovl_a[0]), .out_ready(ordy_s[0]),
    .busy(busy_a[0]), .overflow(ovf_a[0]));

  product_accumulator #(.n(4), .LEN(4), .G(1)) u1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .in_valid(iv_s[1]), .in_ready(ir_a[1]),
    .prod(prod_s[1]), .acc_out(acc1), .out_valid(ovl_a[1]), .out_ready(ordy_s[1]),
    .busy(busy_a[1]), .overflow(ovf_a[1]));

  product_accumulator #(.n(4), .LEN(1), .G(4)) u2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .in_valid(iv_s[2]), .in_ready(ir_a[2]),
    .prod(prod_s[2]), .acc_out(acc_a[2]), .out_valid(ovl_a[2]), .out_ready(ordy_s[2]),
    .busy(busy_a[2]), .overflow(ovf_a[2]));

  assign acc_a[1] = {3'b000, acc1};

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: a run is "busy" from start to handshake; it holds the exact integer sum of what it took.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mbusy[i] = 1'b0; mtaken[i] = 0; msum[i] = 0;
      end else if (!mbusy[i]) begin
        if (start_s[i]) begin
          mbusy[i] = 1'b1; mtaken[i] = 0; msum[i] = 0;
        end
      end else if (mtaken[i] < lenv(i)) begin
        if (iv_s[i]) begin
          msum[i] += longint'(prod_s[i]); mtaken[i]++;
        end
      end else if (ordy_s[i]) begin
        mbusy[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        longint modv;
        modv = longint'(1) << wv(i);
        check($sformatf("u%0d_in_ready", i),  ir_a[i],   mbusy[i] && mtaken[i] < lenv(i));
        check($sformatf("u%0d_out_valid", i), ovl_a[i],  mbusy[i] && mtaken[i] == lenv(i));
        check($sformatf("u%0d_busy", i),      busy_a[i], mbusy[i]);
        check($sformatf("u%0d_acc_out", i),   acc_a[i],  msum[i] % modv);
        check($sformatf("u%0d_overflow", i),  ovf_a[i],  msum[i] >= modv);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // exp_acc < 0 means no literal expectation (random run); the per-cycle model check still applies.
  task automatic run(input int i, input int unsigned p0, input int unsigned p1,
                     input int unsigned p2, input int unsigned p3, input int gmin,
                     input int gmax, input int hold, input longint exp_acc,
                     input longint exp_ovf, input string nm);
    int unsigned p [4];
    longint modv;
    p = '{p0, p1, p2, p3};
    modv = longint'(1) << wv(i);
    start_s[i] = 1'b1;
    cyc();
    start_s[i] = 1'b0;
    for (int k = 0; k < lenv(i); k++) begin
      repeat ($urandom_range(gmax, gmin)) begin
        iv_s[i] = 1'b0; prod_s[i] = 8'($urandom); start_s[i] = 1'($urandom);
        cyc();
      end
      iv_s[i] = 1'b1; prod_s[i] = 8'(p[k]); start_s[i] = 1'($urandom);
      cyc();
    end
    iv_s[i] = 1'b0;
    start_s[i] = 1'b0;
    check({nm, "_latency"}, ovl_a[i], 1);
    for (int t = 0; t < 20 && !ovl_a[i]; t++) cyc();
    check({nm, "_out_valid_timeout"}, ovl_a[i], 1);
    repeat (hold) begin
      ordy_s[i] = 1'b0; iv_s[i] = 1'($urandom); prod_s[i] = 8'($urandom); start_s[i] = 1'($urandom);
      cyc();
    end
    if (exp_acc >= 0) begin
      check({nm, "_acc"}, acc_a[i], exp_acc);
      check({nm, "_ovf"}, ovf_a[i], exp_ovf);
      check({nm, "_model_sum"}, msum[i] % modv, exp_acc);
    end
    // start during the handshake cycle must be ignored.
    ordy_s[i] = 1'b1; start_s[i] = 1'($urandom); iv_s[i] = 1'($urandom);
    cyc();
    ordy_s[i] = 1'b0; start_s[i] = 1'b0; iv_s[i] = 1'b0;
    check({nm, "_idle_busy"}, busy_a[i], 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0; iv_s[i] = 1'b0; ordy_s[i] = 1'b0; prod_s[i] = 8'd0;
    end
    repeat (2) cyc();
    chk_en = 1'b1;
    check("reset_busy", busy_a[0], 0);
    check("reset_acc", acc_a[0], 0);
    check("reset_in_ready", ir_a[0], 0);
    check("reset_out_valid", ovl_a[0], 0);
    check("reset_overflow", ovf_a[0], 0);
    rst = 1'b0;
    cyc();

    run(0, 2, 42, 180, 15, 0, 0, 5, 239, 0, "basic");
    run(0, 2, 42, 180, 15, 1, 3, 0, 239, 0, "gaps");
    run(1, 225, 225, 225, 225, 0, 0, 0, 388, 1, "ovf");
    run(1, 1, 1, 1, 1, 0, 0, 0, 4, 0, "ovf_next");

    start_s[0] = 1'b1; cyc(); start_s[0] = 1'b0;
    iv_s[0] = 1'b1; prod_s[0] = 8'd7; cyc();
    prod_s[0] = 8'd9; cyc();
    iv_s[0] = 1'b0; rst = 1'b1; cyc();
    rst = 1'b0;
    check("midrst_busy", busy_a[0], 0);
    check("midrst_acc", acc_a[0], 0);
    check("midrst_out_valid", ovl_a[0], 0);
    run(0, 3, 3, 3, 3, 0, 1, 1, 12, 0, "after_rst");

    run(2, 225, 0, 0, 0, 0, 0, 2, 225, 0, "len1");

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 3; i++) begin
        run(i, $urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 0),
            $urandom_range(255, 0), 0, 3, int'($urandom_range(4, 0)), -1, -1, "rand");
        repeat ($urandom_range(2, 0)) cyc();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
